// File: rtl/shoe_loader.sv
// shoe_loader: fills deck RAM with NUM_DECKS ordered 52-card decks, then optionally
// Fisher-Yates shuffles them in place using an on-chip Galois LFSR.
// Latency: one RAM write per cycle during fill (52*NUM_DECKS cycles); each swap
// costs at least 6 cycles. No backpressure; start/seed_load are ignored while busy.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   start            - begin a load (accepted only in IDLE or DONE)
//   shuffle_en       - sampled with start; 1 = shuffle after the fill
//   seed_load, seed  - load LFSR seed while idle (zero seed -> LFSR_SEED_DEF)
//   busy, load_done  - status: busy while running, load_done level in DONE
//   deck_addr, deck_wen, deck_data_in - registered RAM write/read port
//   deck_data_out    - RAM read data, valid one cycle after the address
module shoe_loader #(
  parameter int          NUM_DECKS     = 1,
  parameter int          ADDR_W        = 6,
  parameter logic [15:0] LFSR_SEED_DEF = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              shuffle_en,
  input  logic              seed_load,
  input  logic [15:0]       seed,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W-1:0] deck_addr,
  output logic              deck_wen,
  output logic [6:0]        deck_data_in,
  input  logic [6:0]        deck_data_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_SH_PICK, S_SH_RD_I, S_SH_RD_J,
    S_SH_CAP, S_SH_WR_I, S_SH_WR_J, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(52 * NUM_DECKS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [2:0]        LAST_DECK = 3'(NUM_DECKS - 1);

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              shuffle_q, shuffle_d;
  logic [3:0]        rank_q, rank_d;
  logic [1:0]        suit_q, suit_d;
  logic [2:0]        deck_q, deck_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [6:0]        card_i_q, card_i_d;
  logic              busy_q, busy_d;
  logic              load_done_q, load_done_d;
  logic [ADDR_W-1:0] deck_addr_q, deck_addr_d;
  logic              deck_wen_q, deck_wen_d;
  logic [6:0]        deck_data_in_q, deck_data_in_d;

  logic [ADDR_W-1:0] i_mask;
  logic [ADDR_W-1:0] cand;
  logic [15:0]       lfsr_next;
  logic              start_ok;

  // i_mask = smallest 2^k-1 >= i: bit b is set when any bit at or above b is set in i.
  always_comb begin
    i_mask = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      i_mask[b] = |(i_q >> b);
    end
  end

  assign cand      = lfsr_q[ADDR_W-1:0] & i_mask;
  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    shuffle_d      = shuffle_q;
    rank_d         = rank_q;
    suit_d         = suit_q;
    deck_d         = deck_q;
    i_d            = i_q;
    j_d            = j_q;
    card_i_d       = card_i_q;
    busy_d         = busy_q;
    load_done_d    = load_done_q;
    deck_addr_d    = deck_addr_q;
    deck_wen_d     = 1'b0;
    deck_data_in_d = deck_data_in_q;

    // The LFSR only moves while picking, so a given seed always yields the same
    // permutation. Outside a run the seed port may reload it.
    if (state_q == S_SH_PICK) begin
      lfsr_d = lfsr_next;
    end else if (seed_load && !busy_q) begin
      lfsr_d = (seed == 16'h0000) ? LFSR_SEED_DEF : seed;
    end

    // Output registers are loaded with the action of the state being entered,
    // so deck_* always describe the current state's RAM access.
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d        = S_FILL;
          shuffle_d      = shuffle_en;
          rank_d         = 4'd1;
          suit_d         = 2'd0;
          deck_d         = 3'd0;
          busy_d         = 1'b1;
          load_done_d    = 1'b0;
          deck_addr_d    = '0;
          deck_wen_d     = 1'b1;
          deck_data_in_d = 7'h41;
        end
      end
      S_FILL: begin
        if ((deck_q == LAST_DECK) && (suit_q == 2'd3) && (rank_q == 4'd13)) begin
          if (shuffle_q) begin
            state_d = S_SH_PICK;
            i_d     = LAST_ADDR;
          end else begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            load_done_d = 1'b1;
          end
        end else begin
          if (rank_q == 4'd13) begin
            rank_d = 4'd1;
            if (suit_q == 2'd3) begin
              suit_d = 2'd0;
              deck_d = deck_q + 3'd1;
            end else begin
              suit_d = suit_q + 2'd1;
            end
          end else begin
            rank_d = rank_q + 4'd1;
          end
          deck_addr_d    = deck_addr_q + ADDR_ONE;
          deck_wen_d     = 1'b1;
          deck_data_in_d = {1'b1, suit_d, rank_d};
        end
      end
      S_SH_PICK: begin
        // Rejection sampling keeps j uniform over 0..i.
        j_d = cand;
        if (cand <= i_q) begin
          state_d     = S_SH_RD_I;
          deck_addr_d = i_q;
        end
      end
      S_SH_RD_I: begin
        state_d     = S_SH_RD_J;
        deck_addr_d = j_q;
      end
      S_SH_RD_J: begin
        card_i_d = deck_data_out;
        state_d  = S_SH_CAP;
      end
      S_SH_CAP: begin
        // card_j arrives now and goes straight into the write-data register.
        state_d        = S_SH_WR_I;
        deck_addr_d    = i_q;
        deck_data_in_d = deck_data_out;
        deck_wen_d     = 1'b1;
      end
      S_SH_WR_I: begin
        state_d        = S_SH_WR_J;
        deck_addr_d    = j_q;
        deck_data_in_d = card_i_q;
        deck_wen_d     = 1'b1;
      end
      S_SH_WR_J: begin
        i_d = i_q - ADDR_ONE;
        if (i_q == ADDR_ONE) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          load_done_d = 1'b1;
        end else begin
          state_d = S_SH_PICK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      lfsr_q         <= LFSR_SEED_DEF;
      shuffle_q      <= 1'b0;
      rank_q         <= 4'd1;
      suit_q         <= 2'd0;
      deck_q         <= 3'd0;
      i_q            <= '0;
      j_q            <= '0;
      card_i_q       <= '0;
      busy_q         <= 1'b0;
      load_done_q    <= 1'b0;
      deck_addr_q    <= '0;
      deck_wen_q     <= 1'b0;
      deck_data_in_q <= '0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      shuffle_q      <= shuffle_d;
      rank_q         <= rank_d;
      suit_q         <= suit_d;
      deck_q         <= deck_d;
      i_q            <= i_d;
      j_q            <= j_d;
      card_i_q       <= card_i_d;
      busy_q         <= busy_d;
      load_done_q    <= load_done_d;
      deck_addr_q    <= deck_addr_d;
      deck_wen_q     <= deck_wen_d;
      deck_data_in_q <= deck_data_in_d;
    end
  end

  assign busy         = busy_q;
  assign load_done    = load_done_q;
  assign deck_addr    = deck_addr_q;
  assign deck_wen     = deck_wen_q;
  assign deck_data_in = deck_data_in_q;

endmodule

// File: tb/tb_shoe_loader.sv
module tb_shoe_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start, shuffle_en, seed_load, start2;
  logic [15:0] seed;
  logic        busy, load_done, deck_wen;
  logic [5:0]  deck_addr;
  logic [6:0]  deck_data_in, deck_data_out;
  logic        busy2, load_done2, deck_wen2;
  logic [6:0]  deck_addr2;
  logic [6:0]  deck_data_in2, deck_data_out2;

  shoe_loader #(.NUM_DECKS(1), .ADDR_W(6), .LFSR_SEED_DEF(16'hACE1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .shuffle_en(shuffle_en),
    .seed_load(seed_load), .seed(seed), .busy(busy), .load_done(load_done),
    .deck_addr(deck_addr), .deck_wen(deck_wen), .deck_data_in(deck_data_in),
    .deck_data_out(deck_data_out)
  );

  shoe_loader #(.NUM_DECKS(2), .ADDR_W(7), .LFSR_SEED_DEF(16'hACE1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .shuffle_en(1'b0),
    .seed_load(1'b0), .seed(16'h0000), .busy(busy2), .load_done(load_done2),
    .deck_addr(deck_addr2), .deck_wen(deck_wen2), .deck_data_in(deck_data_in2),
    .deck_data_out(deck_data_out2)
  );

  // Behavioural single-port synchronous RAMs, 1-cycle read latency.
  logic [6:0] ram1 [64];
  logic [6:0] ram2 [128];
  always @(posedge clk) begin
    if (deck_wen) ram1[deck_addr] <= deck_data_in;
    deck_data_out <= ram1[deck_addr];
  end
  always @(posedge clk) begin
    if (deck_wen2) ram2[deck_addr2] <= deck_data_in2;
    deck_data_out2 <= ram2[deck_addr2];
  end

  int checks = 0;
  int errors = 0;

  // Run log for the 1-deck DUT.
  int   wa[$], wd[$], wc[$];
  int   done_cyc, busy_gap;
  logic first_busy, first_ld, busy_at_done;

  // Reference model results.
  int exp_img[52];
  int exp_i[$], exp_j[$], exp_di[$], exp_dj[$];
  int img_a[52], img_b[52];

  function automatic int code_of(int idx);
    int r;
    r = idx % 52;
    return 64 + (r / 13) * 16 + (r % 13) + 1;
  endfunction

  function automatic logic [15:0] lfsr_step(logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // Fisher-Yates over an ordered 52-card array, drawing j by rejection from the LFSR.
  task automatic model_shuffle(input logic [15:0] s);
    logic [15:0] l;
    int m, j, t;
    l = (s == 16'h0000) ? 16'hACE1 : s;
    for (int k = 0; k < 52; k++) exp_img[k] = code_of(k);
    exp_i.delete(); exp_j.delete(); exp_di.delete(); exp_dj.delete();
    for (int i = 51; i >= 1; i--) begin
      m = 1;
      while (m < i) m = m * 2 + 1;
      do begin
        j = int'(l) & m;
        l = lfsr_step(l);
      end while (j > i);
      exp_i.push_back(i);
      exp_j.push_back(j);
      exp_di.push_back(exp_img[j]);
      exp_dj.push_back(exp_img[i]);
      t = exp_img[i]; exp_img[i] = exp_img[j]; exp_img[j] = t;
    end
  endtask

  // Launch a run on the 1-deck DUT and log every write until load_done.
  // ld_mode: 0 = no seed load, 1 = seed_load with start, 2 = seed_load the cycle before.
  task automatic run_collect(input bit shuf, input int ld_mode, input logic [15:0] sd, input bit poke);
    wa.delete(); wd.delete(); wc.delete();
    busy_gap = 0;
    done_cyc = -1;
    busy_at_done = 1'b1;
    if (ld_mode == 2) begin
      seed = sd; seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
    end
    start = 1'b1; shuffle_en = shuf; seed = sd; seed_load = (ld_mode == 1);
    @(negedge clk);
    for (int k = 0; k < 6000; k++) begin
      start = 1'b0; seed_load = 1'b0;
      if (k == 0) begin first_busy = busy; first_ld = load_done; end
      if (deck_wen === 1'b1) begin
        wa.push_back(int'(deck_addr)); wd.push_back(int'(deck_data_in)); wc.push_back(k);
      end
      if (load_done === 1'b1) begin done_cyc = k; busy_at_done = busy; break; end
      if (busy !== 1'b1) busy_gap++;
      if (poke && (k == 10 || k == 70)) begin
        start = 1'b1; seed_load = 1'b1; seed = 16'h4321; shuffle_en = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", busy); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %0d expected 0", load_done); end
    checks++; if (deck_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", deck_addr); end
    checks++; if (deck_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0d expected 0", deck_wen); end
    checks++; if (deck_data_in !== 7'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", deck_data_in); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill;
    int bad;
    run_collect(1'b0, 0, 16'h0000, 1'b0);
    checks++; if (done_cyc !== 52) begin errors++; $display("FAIL fill_done_cycle: got %0d expected 52", done_cyc); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL fill_busy_at_done: got %0d expected 0", busy_at_done); end
    checks++; if (first_busy !== 1'b1) begin errors++; $display("FAIL fill_busy_first: got %0d expected 1", first_busy); end
    checks++; if (busy_gap !== 0) begin errors++; $display("FAIL fill_busy_gap: got %0d expected 0", busy_gap); end
    checks++; if (wa.size() !== 52) begin errors++; $display("FAIL fill_write_count: got %0d expected 52", wa.size()); end
    bad = 0;
    for (int k = 0; k < wa.size(); k++)
      if (wa[k] != k || wc[k] != k || wd[k] != code_of(k)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL fill_write_seq: got %0d bad writes expected 0", bad); end
    checks++; if (ram1[0] !== 7'h41) begin errors++; $display("FAIL fill_addr0: got %h expected 41", ram1[0]); end
    checks++; if (ram1[12] !== 7'h4D) begin errors++; $display("FAIL fill_addr12: got %h expected 4d", ram1[12]); end
    checks++; if (ram1[13] !== 7'h51) begin errors++; $display("FAIL fill_addr13: got %h expected 51", ram1[13]); end
    checks++; if (ram1[51] !== 7'h7D) begin errors++; $display("FAIL fill_addr51: got %h expected 7d", ram1[51]); end
    @(negedge clk);
    checks++; if (load_done !== 1'b1 || deck_wen !== 1'b0) begin
      errors++; $display("FAIL done_hold: got load_done=%0d wen=%0d expected 1/0", load_done, deck_wen); end
  endtask

  task automatic test_two_decks;
    int a2[$], d2[$];
    int dk, bad, maxa;
    dk = -1; maxa = 0;
    start2 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 1000; k++) begin
      start2 = 1'b0;
      if (deck_wen2 === 1'b1) begin a2.push_back(int'(deck_addr2)); d2.push_back(int'(deck_data_in2)); end
      if (load_done2 === 1'b1) begin dk = k; break; end
      @(negedge clk);
    end
    checks++; if (dk !== 104) begin errors++; $display("FAIL two_done_cycle: got %0d expected 104", dk); end
    checks++; if (a2.size() !== 104) begin errors++; $display("FAIL two_write_count: got %0d expected 104", a2.size()); end
    bad = 0;
    for (int k = 0; k < a2.size(); k++) begin
      if (a2[k] > maxa) maxa = a2[k];
      if (a2[k] != k || d2[k] != code_of(k)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL two_write_seq: got %0d bad writes expected 0", bad); end
    checks++; if (maxa >= 104) begin errors++; $display("FAIL two_max_addr: got %0d expected below 104", maxa); end
    checks++; if (ram2[52] !== 7'h41) begin errors++; $display("FAIL two_addr52: got %h expected 41", ram2[52]); end
    checks++; if (ram2[103] !== 7'h7D) begin errors++; $display("FAIL two_addr103: got %h expected 7d", ram2[103]); end
  endtask

  task automatic test_shuffle;
    logic [15:0] t_seed [6];
    int          t_mode [6];
    bit          t_poke [6];
    int bad, diff, fill_bad;
    int cnt [128];
    t_seed = '{16'h1234, 16'h1234, 16'h4321, 16'h1234, 16'h0000, 16'hACE1};
    t_mode = '{1, 1, 1, 1, 2, 2};
    t_poke = '{0, 0, 0, 1, 0, 0};
    for (int r = 0; r < 6; r++) begin
      model_shuffle(t_seed[r]);
      run_collect(1'b1, t_mode[r], t_seed[r], t_poke[r]);
      checks++; if (done_cyc < 0) begin errors++; $display("FAIL shuf%0d_timeout: got no load_done expected done", r); end
      checks++; if (busy_gap !== 0) begin errors++; $display("FAIL shuf%0d_busy_gap: got %0d expected 0", r, busy_gap); end
      checks++; if (wa.size() !== 154) begin errors++; $display("FAIL shuf%0d_write_count: got %0d expected 154", r, wa.size()); end
      if (wa.size() == 154) begin
        fill_bad = 0;
        for (int k = 0; k < 52; k++) if (wa[k] != k || wd[k] != code_of(k)) fill_bad++;
        checks++; if (fill_bad !== 0) begin errors++; $display("FAIL shuf%0d_fill: got %0d bad writes expected 0", r, fill_bad); end
        bad = 0;
        for (int s = 0; s < 51; s++) begin
          int p;
          p = 52 + 2 * s;
          if (wa[p] != exp_i[s] || wa[p+1] != exp_j[s] || wd[p] != exp_di[s] ||
              wd[p+1] != exp_dj[s] || wc[p+1] != wc[p] + 1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL shuf%0d_swap_pairs: got %0d bad pairs expected 0", r, bad); end
      end
      bad = 0;
      for (int a = 0; a < 52; a++) if (int'(ram1[a]) != exp_img[a]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL shuf%0d_image: got %0d wrong cards expected 0", r, bad); end
      for (int c = 0; c < 128; c++) cnt[c] = 0;
      for (int a = 0; a < 52; a++) cnt[ram1[a]]++;
      bad = 0;
      for (int k = 0; k < 52; k++) if (cnt[code_of(k)] != 1) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL shuf%0d_permutation: got %0d bad codes expected 0", r, bad); end
      diff = 0;
      for (int a = 0; a < 52; a++) if (int'(ram1[a]) != img_a[a]) diff++;
      if (r == 0) for (int a = 0; a < 52; a++) img_a[a] = int'(ram1[a]);
      if (r == 1) begin
        checks++; if (diff !== 0) begin errors++; $display("FAIL shuf_repeat_same: got %0d differing cards expected 0", diff); end
      end
      if (r == 2) begin
        checks++; if (diff === 0) begin errors++; $display("FAIL shuf_other_seed: got 0 differing cards expected nonzero"); end
      end
      if (r == 4) for (int a = 0; a < 52; a++) img_b[a] = int'(ram1[a]);
      if (r == 5) begin
        diff = 0;
        for (int a = 0; a < 52; a++) if (int'(ram1[a]) != img_b[a]) diff++;
        checks++; if (diff !== 0) begin errors++; $display("FAIL shuf_zero_seed: got %0d differing cards expected 0", diff); end
      end
    end
  endtask

  task automatic test_done_restart;
    int bad;
    run_collect(1'b0, 0, 16'h0000, 1'b0);
    checks++; if (first_ld !== 1'b0) begin errors++; $display("FAIL restart_load_done: got %0d expected 0", first_ld); end
    checks++; if (first_busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %0d expected 1", first_busy); end
    checks++; if (done_cyc !== 52) begin errors++; $display("FAIL restart_done_cycle: got %0d expected 52", done_cyc); end
    bad = 0;
    for (int k = 0; k < wa.size(); k++) if (wa[k] != k || wd[k] != code_of(k)) bad++;
    checks++; if (bad !== 0 || wa.size() !== 52) begin
      errors++; $display("FAIL restart_writes: got %0d writes %0d bad expected 52/0", wa.size(), bad); end
  endtask

  task automatic test_rst_mid;
    int found, bad;
    found = 0;
    start = 1'b1; shuffle_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (deck_wen === 1'b1 && deck_addr === 6'd20) begin found = 1; break; end
      @(negedge clk);
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL rst_mid_reach20: got %0d expected 1", found); end
    rst = 1'b1;
    #1;
    checks++; if ({busy, load_done, deck_wen} !== 3'b000 || deck_addr !== 6'd0 || deck_data_in !== 7'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got busy=%0d ld=%0d wen=%0d addr=%0d data=%0d expected all 0",
                         busy, load_done, deck_wen, deck_addr, deck_data_in); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_collect(1'b0, 0, 16'h0000, 1'b0);
    bad = 0;
    for (int k = 0; k < wa.size(); k++) if (wa[k] != k || wd[k] != code_of(k)) bad++;
    checks++; if (done_cyc !== 52 || wa.size() !== 52 || bad !== 0) begin
      errors++; $display("FAIL rst_mid_refill: got done=%0d writes=%0d bad=%0d expected 52/52/0", done_cyc, wa.size(), bad); end
    // No seed load since reset, so the LFSR must still hold its reset value.
    model_shuffle(16'hACE1);
    run_collect(1'b1, 0, 16'h0000, 1'b0);
    bad = 0;
    for (int a = 0; a < 52; a++) if (int'(ram1[a]) != exp_img[a]) bad++;
    checks++; if (done_cyc < 0 || bad !== 0) begin
      errors++; $display("FAIL reset_seed_image: got done=%0d wrong=%0d expected done and 0", done_cyc, bad); end
  endtask

  task automatic test_random;
    logic [15:0] sd;
    int gap, bad;
    for (int it = 0; it < 4; it++) begin
      sd  = (it == 1) ? 16'h0000 : 16'($urandom_range(0, 65535));
      gap = $urandom_range(0, 4);
      repeat (gap) @(negedge clk);
      model_shuffle(sd);
      run_collect(1'b1, 1 + (it % 2), sd, 1'b0);
      bad = 0;
      for (int a = 0; a < 52; a++) if (int'(ram1[a]) != exp_img[a]) bad++;
      if (wa.size() != 154) bad += 1000;
      checks++; if (done_cyc < 0 || bad !== 0) begin
        errors++; $display("FAIL random%0d_seed_%h: got done=%0d bad=%0d expected done and 0", it, sd, done_cyc, bad); end
    end
  endtask

  initial begin
    start = 1'b0; shuffle_en = 1'b0; seed_load = 1'b0; seed = 16'h0000; start2 = 1'b0;
    for (int a = 0; a < 64; a++) ram1[a] = 7'd0;
    for (int a = 0; a < 128; a++) ram2[a] = 7'd0;
    test_reset();
    test_fill();
    test_two_decks();
    test_shuffle();
    test_done_restart();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shoe_loader.md
Name: shoe_loader

Overview:
- Parametrised successor to the single-deck loader.
- Fills deck RAM with NUM_DECKS ordered 52-card decks (a "shoe").
- Optionally performs an in-place Fisher-Yates shuffle using an on-chip LFSR and the RAM's read port.
- Sits between the game controller (start/done handshake) and the deck RAM (single-port, synchronous, 1-cycle read latency).

Parameters:
- NUM_DECKS, 1, number of decks loaded; legal range 1..8.
- ADDR_W, 6, deck RAM address width; must satisfy 2^ADDR_W >= 52*NUM_DECKS.
- LFSR_SEED_DEF, 16'hACE1, LFSR reset value; also substituted whenever a zero seed is loaded.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin load; sampled only in IDLE or DONE.
- shuffle_en  in  1  sampled with start; 1 = shuffle after fill.
- seed_load  in  1  load seed into LFSR; honoured only when busy=0.
- seed  in  16  LFSR seed value.
- busy  out  1  high from the cycle after an accepted start until entry to DONE.
- load_done  out  1  level; high in DONE, cleared by the next accepted start.
- deck_addr  out  ADDR_W  RAM address.
- deck_wen  out  1  RAM write enable.
- deck_data_in  out  7  RAM write data (card code).
- deck_data_out  in  7  RAM read data, valid the cycle after the address is driven with deck_wen=0.

Behaviour:
- Reset values: state=IDLE, busy=0, load_done=0, deck_addr=0, deck_wen=0, deck_data_in=0, LFSR=LFSR_SEED_DEF.
- All outputs are registered.
- Card code: {1'b1, suit[1:0], rank[3:0]}, rank 1..13, suit 0..3.
- Address of card (deck d, suit s, rank r) = d*52 + s*13 + (r-1). Ordered fill writes exactly this mapping.
- N = 52*NUM_DECKS.
- FILL:
  - One write per cycle, addresses 0..N-1 ascending, deck_wen=1 each cycle.
  - Rank, suit and deck counters are nested and wrap 13 -> 1, 3 -> 0.
  - After address N-1: go to DONE if shuffle_en was 0, else to SH_PICK with i=N-1.
- SH_PICK:
  - LFSR advances one step per cycle (Galois, taps 0xB400).
  - Candidate j = LFSR & mask(i), where mask(i) = smallest 2^k-1 >= i.
  - If j > i, reject and stay in SH_PICK next cycle. Else go to SH_RD_I.
- Swap sequence, each state one cycle:
  - SH_RD_I: addr=i, wen=0.
  - SH_RD_J: addr=j, wen=0; capture card_i.
  - SH_CAP: capture card_j.
  - SH_WR_I: addr=i, data=card_j, wen=1.
  - SH_WR_J: addr=j, data=card_i, wen=1.
  - Then i <= i-1. If i was 1, go to DONE; else return to SH_PICK.
  - j==i is legal; the same card is rewritten.
- DONE: load_done=1, deck_wen=0. An accepted start clears load_done and restarts from FILL, address 0.
- Control handshake:
  - start while busy=1 is ignored.
  - seed_load while busy=1 is ignored.
  - seed_load and start in the same idle cycle: the seed is loaded first and is used for that run.
  - seed==0 loads LFSR_SEED_DEF.
- LFSR advances only in SH_PICK, so the same seed and NUM_DECKS produce an identical permutation.
- deck_wen=0 in every state other than FILL, SH_WR_I and SH_WR_J.
- rst asserted mid-operation: immediate return to reset values. A partial RAM image is left as-is; the next start fully rewrites it.

Test Plan:
- NUM_DECKS=1, start with shuffle_en=0 -> 52 writes over 52 consecutive cycles at addr 0..51. Expected data: addr0=0x41, addr12=0x4D, addr13=0x51, addr51=0x7D. load_done rises the cycle after the last write; busy falls the same cycle.
- NUM_DECKS=2, ADDR_W=7, unshuffled -> 104 writes. addr52=0x41, addr103=0x7D. No write with addr>=104.
- NUM_DECKS=1, seed=0x1234, shuffle_en=1, behavioural RAM model:
  - Final image is a permutation: each of the 52 codes appears exactly once.
  - Every write occurs only in a swap pair.
  - A second run with the same seed gives a bit-identical image; seed=0x4321 gives a different image.
- start pulsed during FILL and during a shuffle -> no effect on addresses or data. seed_load with seed=0 while idle -> result identical to a seed=0xACE1 run.
- rst asserted at FILL address 20 -> all outputs 0 in the same cycle. A subsequent start rewrites from addr 0 and completes with load_done=1.
- Start issued while in DONE -> load_done drops the next cycle, busy=1, and a full fill repeats.
